// File: rtl/camera_bayer_pkg.sv
// Shared defaults and FSM encoding for the raw Bayer capture stage.
package camera_bayer_pkg;
    localparam int DATA_W_DEF  = 12;
    localparam int COORD_W_DEF = 12;
    localparam int FCNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DROP    = 2'd3
    } cap_state_t;
endpackage

// File: rtl/camera_sync_edge.sv
// Registers FVAL/LVAL once; edge pulses compare the live input against the registered copy.
module camera_sync_edge (
    input  logic CAMERA_PIXCLK,
    input  logic reset_n,
    input  logic fval,
    input  logic lval,
    output logic fval_rise,
    output logic fval_fall,
    output logic lval_fall
);
    logic fval_q;
    logic lval_q;

    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            fval_q <= 1'b0;
            lval_q <= 1'b0;
        end else begin
            fval_q <= fval;
            lval_q <= lval;
        end
    end

    assign fval_rise = fval & ~fval_q;
    assign fval_fall = ~fval & fval_q;
    assign lval_fall = ~lval & lval_q;
endmodule

// File: rtl/camera_bayer_roi_capture.sv
// Bayer capture: FVAL/LVAL tracking, shadowed ROI crop, frame decimation, geometry and error flags.
// One cycle from sampled pixel to out_*; no backpressure, the sensor stream cannot be stalled.
module camera_bayer_roi_capture
    import camera_bayer_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int FCNT_W  = FCNT_W_DEF
) (
    input  logic               CAMERA_PIXCLK,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  CAMERA_D,
    input  logic               CAMERA_FVAL,
    input  logic               CAMERA_LVAL,
    input  logic               cfg_enable,
    input  logic [COORD_W-1:0] cfg_roi_x0,
    input  logic [COORD_W-1:0] cfg_roi_y0,
    input  logic [COORD_W-1:0] cfg_roi_w,
    input  logic [COORD_W-1:0] cfg_roi_h,
    input  logic [3:0]         cfg_skip,
    input  logic               err_clr,
    output logic [DATA_W-1:0]  out_data,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_valid,
    output logic               out_sof,
    output logic               out_eol,
    output logic               out_eof,
    output logic [COORD_W-1:0] meas_width,
    output logic [COORD_W-1:0] meas_height,
    output logic               meas_valid,
    output logic [FCNT_W-1:0]  frame_cnt,
    output logic               err_geom
);
    localparam int CW1 = COORD_W + 1;

    logic fval_rise, fval_fall, lval_fall;
    cap_state_t state, state_nxt;
    logic latch_cfg;

    logic [COORD_W-1:0] x_cnt, y_cnt, first_len;
    logic [COORD_W-1:0] sh_x0, sh_y0, sh_w, sh_h;
    logic [3:0]         sh_skip, skip_cnt;

    camera_sync_edge u_sync_edge (
        .CAMERA_PIXCLK (CAMERA_PIXCLK),
        .reset_n       (reset_n),
        .fval          (CAMERA_FVAL),
        .lval          (CAMERA_LVAL),
        .fval_rise     (fval_rise),
        .fval_fall     (fval_fall),
        .lval_fall     (lval_fall)
    );

    // ROI math carries one extra bit so x0+w beyond the coordinate range cannot wrap.
    logic           pix, in_frame, roi_empty, x_in, y_in, cap_pix, err_set;
    logic [CW1-1:0] dx, dy, x_end, y_end, rows_done;
    logic [COORD_W-1:0] line_w;

    assign pix       = CAMERA_FVAL & CAMERA_LVAL;
    assign in_frame  = (state == ST_CAPTURE) || (state == ST_DROP);
    assign roi_empty = (sh_w == '0) || (sh_h == '0);
    assign dx        = {1'b0, x_cnt} - {1'b0, sh_x0};
    assign dy        = {1'b0, y_cnt} - {1'b0, sh_y0};
    assign x_end     = {1'b0, sh_x0} + {1'b0, sh_w};
    assign y_end     = {1'b0, sh_y0} + {1'b0, sh_h};
    assign x_in      = (x_cnt >= sh_x0) && (dx < {1'b0, sh_w});
    assign y_in      = (y_cnt >= sh_y0) && (dy < {1'b0, sh_h});
    assign cap_pix   = (state == ST_CAPTURE) && pix && x_in && y_in;
    // A line ending on the same edge as the frame still counts toward height.
    assign rows_done = {1'b0, y_cnt} + CW1'(lval_fall);
    assign line_w    = (lval_fall && y_cnt == '0) ? x_cnt : first_len;

    assign err_set = ((state == ST_CAPTURE) && !roi_empty && lval_fall && y_in
                        && ({1'b0, x_cnt} < x_end))
                   | ((state == ST_CAPTURE) && !roi_empty && fval_fall && (rows_done < y_end))
                   | (in_frame && lval_fall && (y_cnt != '0) && (x_cnt != first_len));

    always_comb begin
        state_nxt = state;
        latch_cfg = 1'b0;
        case (state)
            ST_SYNC: if (!CAMERA_FVAL) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!cfg_enable) begin
                    state_nxt = ST_SYNC;
                end else if (fval_rise) begin
                    latch_cfg = 1'b1;
                    state_nxt = (skip_cnt == '0) ? ST_CAPTURE : ST_DROP;
                end
            end
            default: if (fval_fall) state_nxt = cfg_enable ? ST_WAIT : ST_SYNC;
        endcase
    end

    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_SYNC;
            skip_cnt <= '0;
            sh_x0    <= '0;
            sh_y0    <= '0;
            sh_w     <= '0;
            sh_h     <= '0;
            sh_skip  <= '0;
        end else begin
            state <= state_nxt;
            if (latch_cfg) begin
                sh_x0   <= cfg_roi_x0;
                sh_y0   <= cfg_roi_y0;
                sh_w    <= cfg_roi_w;
                sh_h    <= cfg_roi_h;
                sh_skip <= cfg_skip;
            end
            if (latch_cfg && skip_cnt != '0)
                skip_cnt <= skip_cnt - 4'd1;
            else if (state == ST_CAPTURE && fval_fall)
                skip_cnt <= sh_skip;
        end
    end

    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            first_len <= '0;
            frame_cnt <= '0;
            err_geom  <= 1'b0;
        end else begin
            if (lval_fall)
                x_cnt <= '0;
            else if (pix && x_cnt != '1)
                x_cnt <= x_cnt + COORD_W'(1);
            if (fval_fall)
                y_cnt <= '0;
            else if (lval_fall && y_cnt != '1)
                y_cnt <= y_cnt + COORD_W'(1);
            if (lval_fall && y_cnt == '0)
                first_len <= x_cnt;
            if (fval_fall)
                frame_cnt <= frame_cnt + FCNT_W'(1);
            if (err_clr)
                err_geom <= 1'b0;
            else if (err_set)
                err_geom <= 1'b1;
        end
    end

    always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
        if (!reset_n) begin
            out_data    <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_eol     <= 1'b0;
            out_eof     <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            meas_valid  <= 1'b0;
        end else begin
            out_data  <= CAMERA_D;
            out_x     <= dx[COORD_W-1:0];
            out_y     <= dy[COORD_W-1:0];
            out_valid <= cap_pix;
            out_sof   <= cap_pix && (dx == '0) && (dy == '0);
            out_eol   <= cap_pix && (dx[COORD_W-1:0] == sh_w - COORD_W'(1));
            out_eof   <= cap_pix && (dx[COORD_W-1:0] == sh_w - COORD_W'(1))
                                 && (dy[COORD_W-1:0] == sh_h - COORD_W'(1));
            meas_valid <= fval_fall && in_frame;
            if (fval_fall && in_frame) begin
                meas_width  <= line_w;
                meas_height <= rows_done[COORD_W] ? '1 : rows_done[COORD_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_camera_bayer_roi_capture.sv
// Scoreboard bench: the frame driver queues expected pixels/geometry, a negedge monitor checks them.
module tb_camera_bayer_roi_capture;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] CAMERA_D = '0;
    logic        CAMERA_FVAL = 1'b0, CAMERA_LVAL = 1'b0;
    logic        cfg_enable = 1'b1;
    logic [11:0] cfg_roi_x0 = '0, cfg_roi_y0 = '0, cfg_roi_w = '0, cfg_roi_h = '0;
    logic [3:0]  cfg_skip = '0;
    logic        err_clr = 1'b0;
    logic [11:0] out_data, out_x, out_y, meas_width, meas_height;
    logic        out_valid, out_sof, out_eol, out_eof, meas_valid, err_geom;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    camera_bayer_roi_capture dut (
        .CAMERA_PIXCLK(clk), .reset_n(reset_n), .CAMERA_D(CAMERA_D),
        .CAMERA_FVAL(CAMERA_FVAL), .CAMERA_LVAL(CAMERA_LVAL), .cfg_enable(cfg_enable),
        .cfg_roi_x0(cfg_roi_x0), .cfg_roi_y0(cfg_roi_y0), .cfg_roi_w(cfg_roi_w),
        .cfg_roi_h(cfg_roi_h), .cfg_skip(cfg_skip), .err_clr(err_clr),
        .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_valid(out_valid),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .meas_width(meas_width), .meas_height(meas_height), .meas_valid(meas_valid),
        .frame_cnt(frame_cnt), .err_geom(err_geom)
    );

    typedef struct packed {
        logic [11:0] d;
        logic [11:0] x;
        logic [11:0] y;
        logic        sof;
        logic        eol;
        logic        eof;
    } pix_t;
    typedef struct packed {
        logic [11:0] w;
        logic [11:0] h;
    } geo_t;

    pix_t exp_q[$];
    geo_t geo_q[$];
    pix_t mon_a, mon_e;
    geo_t geo_a, geo_e;
    int vectors = 0;
    int miscompares = 0;
    int nx0, ny0, nw, nh;
    logic [15:0] fc0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_roi(input int x0, input int y0, input int w, input int h);
        cfg_roi_x0 = 12'(x0);
        cfg_roi_y0 = 12'(y0);
        cfg_roi_w  = 12'(w);
        cfg_roi_h  = 12'(h);
    endtask

    // Drives one frame; cap/meas say whether the DUT should output pixels / report geometry.
    task automatic send_frame(input int cols, input int rows, input bit cap, input bit meas,
                              input bit tight, input int short_row, input int chg_row);
        int x0, y0, w, h, len, dx, dy;
        x0 = int'(cfg_roi_x0);
        y0 = int'(cfg_roi_y0);
        w  = int'(cfg_roi_w);
        h  = int'(cfg_roi_h);
        if (meas) geo_q.push_back('{w: 12'(cols), h: 12'(rows)});
        CAMERA_FVAL = 1'b1;
        tick();
        tick();
        for (int y = 0; y < rows; y++) begin
            len = (y == short_row) ? cols - 3 : cols;
            if (y == chg_row) set_roi(nx0, ny0, nw, nh);
            for (int x = 0; x < len; x++) begin
                CAMERA_LVAL = 1'b1;
                CAMERA_D    = 12'((y << 7) + x);
                dx = x - x0;
                dy = y - y0;
                if (cap && dx >= 0 && dx < w && dy >= 0 && dy < h)
                    exp_q.push_back('{d: CAMERA_D, x: 12'(dx), y: 12'(dy),
                                      sof: (dx == 0 && dy == 0), eol: (dx == w - 1),
                                      eof: (dx == w - 1 && dy == h - 1)});
                tick();
            end
            CAMERA_LVAL = 1'b0;
            if (tight && y == rows - 1) CAMERA_FVAL = 1'b0;
            repeat (3) tick();
        end
        CAMERA_FVAL = 1'b0;
        repeat (4) tick();
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid) begin
                mon_a = '{d: out_data, x: out_x, y: out_y, sof: out_sof, eol: out_eol, eof: out_eof};
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected pixel: got %0h expected none", mon_a);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pixel", 64'(mon_a), 64'(mon_e));
                end
            end
            if (meas_valid) begin
                geo_a = '{w: meas_width, h: meas_height};
                if (geo_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected meas_valid: got %0h expected none", geo_a);
                end else begin
                    geo_e = geo_q.pop_front();
                    check("geometry", 64'(geo_a), 64'(geo_e));
                end
            end
        end
    end

    initial begin
        set_roi(0, 0, 16, 8);
        repeat (3) tick();
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_sof", 64'(out_sof), 64'd0);
        check("rst meas_valid", 64'(meas_valid), 64'd0);
        check("rst meas_width", 64'(meas_width), 64'd0);
        check("rst frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst err_geom", 64'(err_geom), 64'd0);
        reset_n = 1'b1;
        repeat (3) tick();

        // full-frame ROI
        send_frame(16, 8, 1, 1, 0, -1, -1);
        check("full frame_cnt", 64'(frame_cnt), 64'd1);
        check("full err_geom", 64'(err_geom), 64'd0);

        // w=1: every pixel EOL
        set_roi(2, 0, 1, 3);
        send_frame(8, 4, 1, 1, 0, -1, -1);

        // 1x1 ROI on the last pixel, FVAL and LVAL falling together
        set_roi(7, 3, 1, 1);
        send_frame(8, 4, 1, 1, 1, -1, -1);
        check("tight err_geom", 64'(err_geom), 64'd0);

        // offset crop
        set_roi(100, 50, 4, 2);
        send_frame(110, 54, 1, 1, 0, -1, -1);
        check("crop err_geom", 64'(err_geom), 64'd0);

        // decimation: capture, drop, drop, capture, drop, drop
        set_roi(0, 0, 4, 2);
        cfg_skip = 4'd2;
        fc0 = frame_cnt;
        for (int i = 0; i < 6; i++) send_frame(4, 2, (i % 3) == 0, 1, 0, -1, -1);
        check("skip frame_cnt", 64'(frame_cnt), 64'(16'(fc0 + 16'd6)));
        cfg_skip = 4'd0;

        // ROI rewritten mid-frame takes effect on the next frame only
        set_roi(1, 1, 2, 2);
        nx0 = 0; ny0 = 0; nw = 3; nh = 1;
        send_frame(8, 4, 1, 1, 0, -1, 2);
        send_frame(8, 4, 1, 1, 0, -1, -1);

        // short line 10
        set_roi(0, 0, 16, 14);
        send_frame(16, 14, 1, 1, 0, 10, -1);
        check("short err_geom set", 64'(err_geom), 64'd1);
        tick();
        check("short err_geom sticky", 64'(err_geom), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", 64'(err_geom), 64'd0);

        // reset mid-line; ROI rows 2..3 must never appear from the interrupted frame
        set_roi(0, 2, 8, 2);
        fork
            send_frame(8, 4, 0, 0, 0, -1, -1);
            begin
                repeat (17) tick();
                reset_n = 1'b0;
                tick();
                check("midrst out_valid", 64'(out_valid), 64'd0);
                check("midrst frame_cnt", 64'(frame_cnt), 64'd0);
                check("midrst meas_width", 64'(meas_width), 64'd0);
                repeat (2) tick();
                reset_n = 1'b1;
            end
        join
        send_frame(8, 4, 1, 1, 0, -1, -1);
        check("post-reset frame_cnt", 64'(frame_cnt), 64'd2);
        check("post-reset err_geom", 64'(err_geom), 64'd0);

        repeat (5) tick();
        check("pixels left in queue", 64'(exp_q.size()), 64'd0);
        check("geometry left in queue", 64'(geo_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
